// File: rtl/sd_data_pkg.sv
// Shared definitions for the SD-host data-path controller: state encoding and default widths.
package sd_data_pkg;

    localparam int unsigned BLOCKS_W_DEF  = 8;
    localparam int unsigned TIMEOUT_W_DEF = 16;

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] SETUP      = 3'd1;
    localparam logic [2:0] CHECK_FIFO = 3'd2;
    localparam logic [2:0] TRANSMIT   = 3'd3;
    localparam logic [2:0] ACK        = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE       = IDLE,
        ST_SETUP      = SETUP,
        ST_CHECK_FIFO = CHECK_FIFO,
        ST_TRANSMIT   = TRANSMIT,
        ST_ACK        = ACK
    } data_state_t;

endpackage

// File: rtl/sd_data_control.sv
// SD-host data-path control FSM: latches transfer setup and sequences blocks through the physical layer.
// Build option: define DATA_CTRL_TIMEOUT_ABORT_EN to let iTimeout abort a block in TRANSMIT.
module sd_data_control
    import sd_data_pkg::*;
#(
    parameter int unsigned BLOCKS_W  = BLOCKS_W_DEF,
    parameter int unsigned TIMEOUT_W = TIMEOUT_W_DEF
) (
    input  logic                 iClock,
    input  logic                 iReset,
    input  logic                 iWriteRead,
    input  logic [BLOCKS_W-1:0]  iBlocks,
    input  logic                 iMultipleData,
    input  logic                 iTimeout_enable,
    input  logic [TIMEOUT_W-1:0] iTimeout_reg,
    input  logic                 iNewData,
    input  logic                 iSerial_ready,
    input  logic                 iTimeout,
    input  logic                 iComplete,
    input  logic                 iAck,
    input  logic                 iFIFO_ok,
    output logic                 oData_transfer_complete,
    output logic                 oSend,
    output logic                 oAck,
    output logic [BLOCKS_W-1:0]  oBlocks,
    output logic [TIMEOUT_W-1:0] oTimeout_val,
    output logic                 oWriteRead,
    output logic                 oMultipleData,
    output logic                 oIdle
);

    data_state_t         state;
    logic [BLOCKS_W-1:0] blk_cnt;
    logic [BLOCKS_W:0]   cnt_plus;

    // One extra bit so the terminal compare and saturation never see a wrapped value
    always_comb begin
        cnt_plus = {1'b0, blk_cnt} + (BLOCKS_W + 1)'(1);
    end

`ifndef DATA_CTRL_TIMEOUT_ABORT_EN
    // iTimeout has no effect in this build
    logic timeout_unused;
    assign timeout_unused = iTimeout;
`endif

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state                   <= ST_IDLE;
            blk_cnt                 <= '0;
            oData_transfer_complete <= 1'b0;
            oSend                   <= 1'b0;
            oAck                    <= 1'b0;
            oBlocks                 <= '0;
            oTimeout_val            <= '0;
            oWriteRead              <= 1'b0;
            oMultipleData           <= 1'b0;
            oIdle                   <= 1'b1;
        end else begin
            oData_transfer_complete <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (iNewData) begin
                        state         <= ST_SETUP;
                        oIdle         <= 1'b0;
                        blk_cnt       <= '0;
                        oWriteRead    <= iWriteRead;
                        oMultipleData <= iMultipleData;
                        oBlocks       <= (iBlocks == '0) ? BLOCKS_W'(1) : iBlocks;
                        oTimeout_val  <= iTimeout_enable ? iTimeout_reg : '0;
                    end
                end
                ST_SETUP: begin
                    if (iSerial_ready) begin
                        state <= ST_CHECK_FIFO;
                    end
                end
                ST_CHECK_FIFO: begin
                    if (iFIFO_ok) begin
                        state <= ST_TRANSMIT;
                        oSend <= 1'b1;
                    end
                end
                ST_TRANSMIT: begin
                    // Completion takes priority over a simultaneous timeout
                    if (iComplete) begin
                        state <= ST_ACK;
                        oSend <= 1'b0;
                        oAck  <= 1'b1;
                    end
`ifdef DATA_CTRL_TIMEOUT_ABORT_EN
                    else if (iTimeout) begin
                        state                   <= ST_IDLE;
                        oSend                   <= 1'b0;
                        oIdle                   <= 1'b1;
                        oData_transfer_complete <= 1'b1;
                    end
`endif
                end
                ST_ACK: begin
                    if (iAck) begin
                        oAck    <= 1'b0;
                        blk_cnt <= cnt_plus[BLOCKS_W] ? blk_cnt : cnt_plus[BLOCKS_W-1:0];
                        if (oMultipleData && (cnt_plus < {1'b0, oBlocks})) begin
                            state <= ST_CHECK_FIFO;
                        end else begin
                            state                   <= ST_IDLE;
                            oIdle                   <= 1'b1;
                            oData_transfer_complete <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    oSend <= 1'b0;
                    oAck  <= 1'b0;
                    oIdle <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_data_control.sv
// Directed bench for sd_data_control with a scoreboard of expected send/ack rounds per transfer.
module tb_sd_data_control;

    logic        iClock;
    logic        iReset;
    logic        iWriteRead;
    logic [7:0]  iBlocks;
    logic        iMultipleData;
    logic        iTimeout_enable;
    logic [15:0] iTimeout_reg;
    logic        iNewData;
    logic        iSerial_ready;
    logic        iTimeout;
    logic        iComplete;
    logic        iAck;
    logic        iFIFO_ok;
    logic        oData_transfer_complete;
    logic        oSend;
    logic        oAck;
    logic [7:0]  oBlocks;
    logic [15:0] oTimeout_val;
    logic        oWriteRead;
    logic        oMultipleData;
    logic        oIdle;

    typedef struct {
        int sends;
        int acks;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   sends_seen = 0;
    int   acks_seen = 0;
    int   completes = 0;
    logic prev_send = 1'b0;
    logic prev_ack = 1'b0;

    sd_data_control dut (
        .iClock                  (iClock),
        .iReset                  (iReset),
        .iWriteRead              (iWriteRead),
        .iBlocks                 (iBlocks),
        .iMultipleData           (iMultipleData),
        .iTimeout_enable         (iTimeout_enable),
        .iTimeout_reg            (iTimeout_reg),
        .iNewData                (iNewData),
        .iSerial_ready           (iSerial_ready),
        .iTimeout                (iTimeout),
        .iComplete               (iComplete),
        .iAck                    (iAck),
        .iFIFO_ok                (iFIFO_ok),
        .oData_transfer_complete (oData_transfer_complete),
        .oSend                   (oSend),
        .oAck                    (oAck),
        .oBlocks                 (oBlocks),
        .oTimeout_val            (oTimeout_val),
        .oWriteRead              (oWriteRead),
        .oMultipleData           (oMultipleData),
        .oIdle                   (oIdle)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge iClock);
        #1;
    endtask

    // Counts send/ack rounds and retires one scoreboard entry per completion pulse
    always @(negedge iClock) begin
        if (iReset) begin
            sends_seen = 0;
            acks_seen  = 0;
            prev_send  = 1'b0;
            prev_ack   = 1'b0;
        end else begin
            if (oSend && !prev_send) sends_seen++;
            if (oAck && !prev_ack) acks_seen++;
            prev_send = oSend;
            prev_ack  = oAck;
            if (oData_transfer_complete) begin
                exp_t e;
                completes++;
                checks++;
                assert (sb.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_complete: observed pulse with %0d pending, expected pending entry", sb.size());
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("send_rounds", 32'(sends_seen), 32'(e.sends));
                    check("ack_rounds", 32'(acks_seen), 32'(e.acks));
                    check("idle_at_complete", 32'(oIdle), 32'd1);
                    sends_seen = 0;
                    acks_seen  = 0;
                end
            end
        end
    end

    // mode: 0 plain, 1 lone iTimeout in first TRANSMIT, 2 iTimeout together with iComplete
    task automatic do_transfer(input logic [7:0] blocks, input logic multi, input logic wr,
                               input logic ten, input logic [15:0] treg, input int mode,
                               input bit stall);
        exp_t        e;
        int          rounds;
        int          n;
        logic [7:0]  eb;
        logic [15:0] et;
        eb     = (blocks == 8'd0) ? 8'd1 : blocks;
        et     = ten ? treg : 16'd0;
        rounds = multi ? int'(eb) : 1;
`ifdef DATA_CTRL_TIMEOUT_ABORT_EN
        if (mode == 1) begin
            e.sends = 1;
            e.acks  = 0;
        end else begin
            e.sends = rounds;
            e.acks  = rounds;
        end
`else
        e.sends = rounds;
        e.acks  = rounds;
`endif
        sb.push_back(e);

        iBlocks         = blocks;
        iMultipleData   = multi;
        iWriteRead      = wr;
        iTimeout_enable = ten;
        iTimeout_reg    = treg;
        iNewData        = 1'b1;
        step(1);
        check("latched_blocks", 32'(oBlocks), 32'(eb));
        check("latched_timeout", 32'(oTimeout_val), 32'(et));
        check("latched_dir", 32'(oWriteRead), 32'(wr));
        check("latched_multi", 32'(oMultipleData), 32'(multi));
        check("idle_low_setup", 32'(oIdle), 32'd0);
        // New request and altered inputs outside IDLE must not disturb the latched setup
        iBlocks         = ~blocks;
        iTimeout_reg    = ~treg;
        iTimeout_enable = 1'b1;
        step(1);
        iNewData = 1'b0;
        check("setup_hold_blocks", 32'(oBlocks), 32'(eb));
        check("setup_hold_timeout", 32'(oTimeout_val), 32'(et));
        iSerial_ready = 1'b1;
        step(1);
        iSerial_ready = 1'b0;
        for (int r = 0; r < rounds; r++) begin
            if (stall && r == 0) begin
                iFIFO_ok = 1'b0;
                step(10);
                check("stall_no_send", 32'(oSend), 32'd0);
            end
            iFIFO_ok = 1'b1;
            n = 0;
            while (!oSend && n < 20) begin
                step(1);
                n++;
            end
            check("send_asserted", 32'(oSend), 32'd1);
            iFIFO_ok = 1'b0;
            if (r == 0 && mode == 1) begin
                iTimeout = 1'b1;
                step(1);
                iTimeout = 1'b0;
`ifdef DATA_CTRL_TIMEOUT_ABORT_EN
                check("abort_send_low", 32'(oSend), 32'd0);
                check("abort_idle", 32'(oIdle), 32'd1);
                check("abort_pulse", 32'(oData_transfer_complete), 32'd1);
                step(1);
                check("abort_pulse_len", 32'(oData_transfer_complete), 32'd0);
                return;
`else
                check("timeout_ignored", 32'(oSend), 32'd1);
                step(3);
                check("timeout_still_send", 32'(oSend), 32'd1);
`endif
            end
            check("no_early_ack", 32'(oAck), 32'd0);
            iComplete = 1'b1;
            iTimeout  = (r == 0 && mode == 2);
            step(1);
            iComplete = 1'b0;
            iTimeout  = 1'b0;
            check("ack_high", 32'(oAck), 32'd1);
            check("send_low_in_ack", 32'(oSend), 32'd0);
            iAck = 1'b1;
            step(1);
            iAck = 1'b0;
            check("ack_dropped", 32'(oAck), 32'd0);
            if (r < rounds - 1) begin
                check("no_mid_complete", 32'(oData_transfer_complete), 32'd0);
                check("mid_not_idle", 32'(oIdle), 32'd0);
            end
        end
        check("end_idle", 32'(oIdle), 32'd1);
        check("end_pulse", 32'(oData_transfer_complete), 32'd1);
        step(1);
        check("end_pulse_len", 32'(oData_transfer_complete), 32'd0);
        step(1);
    endtask

    initial begin
        int done_before;
        iReset = 1'b1;
        iWriteRead = 1'b0;
        iBlocks = 8'd0;
        iMultipleData = 1'b0;
        iTimeout_enable = 1'b0;
        iTimeout_reg = 16'd0;
        iNewData = 1'b0;
        iSerial_ready = 1'b0;
        iTimeout = 1'b0;
        iComplete = 1'b0;
        iAck = 1'b0;
        iFIFO_ok = 1'b0;
        step(2);
        check("rst_idle", 32'(oIdle), 32'd1);
        check("rst_send", 32'(oSend), 32'd0);
        check("rst_ack", 32'(oAck), 32'd0);
        check("rst_blocks", 32'(oBlocks), 32'd0);
        check("rst_timeout", 32'(oTimeout_val), 32'd0);
        check("rst_complete", 32'(oData_transfer_complete), 32'd0);
        iReset = 1'b0;
        step(1);

        do_transfer(8'd1, 1'b0, 1'b1, 1'b1, 16'h00FF, 0, 1'b0);  // single write
        do_transfer(8'd3, 1'b1, 1'b0, 1'b1, 16'h0040, 0, 1'b0);  // multi read
        do_transfer(8'd2, 1'b1, 1'b1, 1'b0, 16'h1234, 0, 1'b0);  // timeout disabled
        do_transfer(8'd2, 1'b1, 1'b0, 1'b1, 16'h0010, 0, 1'b1);  // FIFO stall
        do_transfer(8'd5, 1'b0, 1'b1, 1'b1, 16'h0001, 0, 1'b0);  // single-block ignores count
        do_transfer(8'd0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 0, 1'b0);  // zero count -> one block
        do_transfer(8'd2, 1'b1, 1'b1, 1'b1, 16'h0100, 1, 1'b0);  // lone timeout
        do_transfer(8'd1, 1'b0, 1'b0, 1'b1, 16'h0200, 2, 1'b0);  // complete beats timeout

        // Reset in the middle of TRANSMIT
        done_before = completes;
        iBlocks = 8'd4;
        iMultipleData = 1'b1;
        iWriteRead = 1'b1;
        iTimeout_enable = 1'b1;
        iTimeout_reg = 16'hABCD;
        iNewData = 1'b1;
        step(1);
        iNewData = 1'b0;
        iSerial_ready = 1'b1;
        step(1);
        iSerial_ready = 1'b0;
        iFIFO_ok = 1'b1;
        step(1);
        iFIFO_ok = 1'b0;
        check("pre_reset_send", 32'(oSend), 32'd1);
        iReset = 1'b1;
        step(1);
        check("midrst_idle", 32'(oIdle), 32'd1);
        check("midrst_send", 32'(oSend), 32'd0);
        check("midrst_blocks", 32'(oBlocks), 32'd0);
        check("midrst_timeout", 32'(oTimeout_val), 32'd0);
        check("midrst_no_pulse", 32'(oData_transfer_complete), 32'd0);
        iReset = 1'b0;
        step(3);
        check("midrst_no_complete", 32'(completes), 32'(done_before));
        check("midrst_still_idle", 32'(oIdle), 32'd1);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
